// File: rtl/frame_feeder.sv
// Frame feeder: buffers one frame of samples, streams it to a downstream filter,
// then waits (bounded) for the filter result and holds it for a consumer.
module frame_feeder #(
  parameter int FRAME_LEN = 10,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [8:0]  in_data,
  output logic               in_ready,
  output logic signed [8:0]  sig,
  output logic               run,
  input  logic signed [18:0] filter_out,
  input  logic               out_sig,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [18:0] res_data,
  output logic               timeout_err,
  output logic [7:0]         frame_cnt
);

  localparam int CW = 4;
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, STREAM, WAIT, HOLD} state_t;

  state_t                   state_q;
  logic [CW-1:0]            wr_cnt_q, rd_cnt_q;
  logic [WW-1:0]            wait_cnt_q;
  logic                     run_q, res_valid_q, timeout_err_q;
  logic signed [8:0]        sig_q;
  logic signed [18:0]       res_data_q;
  logic [7:0]               frame_cnt_q;
  logic signed [8:0]        buf_q [FRAME_LEN];

  logic [CW-1:0]            wr_cnt_d, rd_cnt_d;
  logic [WW-1:0]            wait_cnt_d;
  logic [7:0]               frame_cnt_d;

  assign wr_cnt_d    = wr_cnt_q + CW'(1);
  assign rd_cnt_d    = rd_cnt_q + CW'(1);
  assign wait_cnt_d  = wait_cnt_q + WW'(1);
  assign frame_cnt_d = frame_cnt_q + 8'd1;

  assign in_ready    = (state_q == LOAD);
  assign sig         = sig_q;
  assign run         = run_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign timeout_err = timeout_err_q;
  assign frame_cnt   = frame_cnt_q;

  // Sample storage is only written while loading, so a frame cannot be
  // overwritten while it is being streamed out.
  always_ff @(posedge clk) begin
    if (!reset && state_q == LOAD && in_valid) begin
      buf_q[wr_cnt_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LOAD;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      run_q         <= 1'b0;
      sig_q         <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        LOAD: begin
          // The first streamed sample is presented on the first STREAM cycle;
          // slot 0 is never the one being written on the final accept.
          if (in_valid) begin
            if (wr_cnt_q == CW'(FRAME_LEN - 1)) begin
              wr_cnt_q <= '0;
              rd_cnt_q <= CW'(1);
              run_q    <= 1'b1;
              sig_q    <= buf_q[0];
              state_q  <= STREAM;
            end else begin
              wr_cnt_q <= wr_cnt_d;
            end
          end
        end
        STREAM: begin
          if (rd_cnt_q == CW'(FRAME_LEN)) begin
            rd_cnt_q   <= '0;
            run_q      <= 1'b0;
            sig_q      <= '0;
            wait_cnt_q <= '0;
            state_q    <= WAIT;
          end else begin
            sig_q    <= buf_q[rd_cnt_q];
            rd_cnt_q <= rd_cnt_d;
          end
        end
        WAIT: begin
          // A result arriving in the last allowed cycle beats the timeout.
          if (out_sig) begin
            res_data_q  <= filter_out;
            res_valid_q <= 1'b1;
            wait_cnt_q  <= '0;
            state_q     <= HOLD;
          end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            wait_cnt_q    <= '0;
            state_q       <= LOAD;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_feeder.sv
// Directed bench for frame_feeder: frame path, backpressure, timeout,
// mid-stream reset, signed extremes and frame counter wrap.
module tb_frame_feeder;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic signed [8:0]  in_data;
  logic               in_ready;
  logic signed [8:0]  sig;
  logic               run;
  logic signed [18:0] filter_out;
  logic               out_sig;
  logic               res_valid;
  logic               res_ready;
  logic signed [18:0] res_data;
  logic               timeout_err;
  logic [7:0]         frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic signed [8:0] frameSmp [10];

  frame_feeder #(.FRAME_LEN(10), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sig(sig), .run(run), .filter_out(filter_out),
    .out_sig(out_sig), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic signed [8:0] d,
                               input logic os, input logic signed [18:0] fo,
                               input logic rr);
    in_valid   = v;
    in_data    = d;
    out_sig    = os;
    filter_out = fo;
    res_ready  = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Leaves the bench on the first STREAM cycle.
  task automatic loadFrame(input bit gapped, input bit chk);
    int n;
    n = gapped ? 19 : 10;
    for (int i = 0; i < n; i++) begin
      if (!gapped || (i % 2 == 0))
        applyStimulus(1'b1, frameSmp[gapped ? i / 2 : i], 1'b0, '0, 1'b0);
      else
        applyStimulus(1'b0, 9'sh0AA, 1'b0, '0, 1'b0);
      if (chk) checkOutput("load_in_ready", {31'b0, in_ready}, 32'd1);
      stepCycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Checks n stream cycles; does not advance past the last one checked.
  task automatic checkStream(input int n);
    for (int k = 0; k < n; k++) begin
      checkOutput("stream_run", {31'b0, run}, 32'd1);
      checkOutput("stream_sig", {23'b0, sig}, {23'b0, frameSmp[k]});
      checkOutput("stream_in_ready", {31'b0, in_ready}, 32'd0);
      if (k < n - 1) stepCycle();
    end
  endtask

  task automatic checkWaitEntry();
    checkOutput("wait_run", {31'b0, run}, 32'd0);
    checkOutput("wait_sig", {23'b0, sig}, 32'd0);
    checkOutput("wait_in_ready", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic quickFrame();
    for (int k = 0; k < 10; k++) frameSmp[k] = 9'(k);
    loadFrame(1'b0, 1'b0);
    repeat (10) stepCycle();
    applyStimulus(1'b0, '0, 1'b1, 19'sh00001, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("rst_run", {31'b0, run}, 32'd0);
    checkOutput("rst_sig", {23'b0, sig}, 32'd0);
    checkOutput("rst_res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("rst_res_data", {13'b0, res_data}, 32'd0);
    checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    checkOutput("rst_frame_cnt", {24'b0, frame_cnt}, 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 10; k++) frameSmp[k] = 9'(201 + k);
    loadFrame(1'b0, 1'b1);
    checkStream(4);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midrst_run", {31'b0, run}, 32'd0);
    checkOutput("midrst_sig", {23'b0, sig}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midrst_frame_cnt", {24'b0, frame_cnt}, 32'd0);
    stepCycle();
    checkOutput("midrst_run_hold", {31'b0, run}, 32'd0);

    $display("[TB] frame path");
    for (int k = 0; k < 10; k++) frameSmp[k] = 9'(k + 1);
    loadFrame(1'b0, 1'b1);
    checkStream(10);
    stepCycle();
    checkWaitEntry();
    checkOutput("path_res_valid_wait", {31'b0, res_valid}, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 19'sh00123, 1'b0);
    stepCycle();
    checkOutput("path_res_valid", {31'b0, res_valid}, 32'd1);
    checkOutput("path_res_data", {13'b0, res_data}, 32'h00123);
    checkOutput("path_hold_in_ready", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("path_res_valid_clr", {31'b0, res_valid}, 32'd0);
    checkOutput("path_frame_cnt", {24'b0, frame_cnt}, 32'd1);
    checkOutput("path_in_ready", {31'b0, in_ready}, 32'd1);

    $display("[TB] backpressure");
    for (int k = 0; k < 10; k++) frameSmp[k] = 9'(100 - 30 * k);
    loadFrame(1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 19'sh55555, 1'b0);
    checkStream(10);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    stepCycle();
    checkWaitEntry();
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_wait_res_valid", {31'b0, res_valid}, 32'd0);
      stepCycle();
    end
    applyStimulus(1'b0, '0, 1'b1, 19'sh0ABCD, 1'b0);
    stepCycle();
    for (int h = 0; h < 5; h++) begin
      checkOutput("bp_hold_res_valid", {31'b0, res_valid}, 32'd1);
      checkOutput("bp_hold_res_data", {13'b0, res_data}, 32'h0ABCD);
      checkOutput("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
      applyStimulus(1'b1, 9'sh033, 1'b1, 19'sh11111, 1'b0);
      stepCycle();
    end
    checkOutput("bp_hold_res_data_end", {13'b0, res_data}, 32'h0ABCD);
    checkOutput("bp_hold_res_valid_end", {31'b0, res_valid}, 32'd1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("bp_res_valid_clr", {31'b0, res_valid}, 32'd0);
    checkOutput("bp_frame_cnt", {24'b0, frame_cnt}, 32'd2);

    $display("[TB] timeout");
    for (int k = 0; k < 10; k++) frameSmp[k] = 9'(7 * k - 30);
    loadFrame(1'b0, 1'b0);
    checkStream(10);
    stepCycle();
    checkWaitEntry();
    for (int c = 0; c < 15; c++) begin
      checkOutput("to_err_early", {31'b0, timeout_err}, 32'd0);
      checkOutput("to_res_valid", {31'b0, res_valid}, 32'd0);
      stepCycle();
    end
    checkOutput("to_err_pulse", {31'b0, timeout_err}, 32'd1);
    checkOutput("to_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("to_res_valid_after", {31'b0, res_valid}, 32'd0);
    checkOutput("to_res_data_kept", {13'b0, res_data}, 32'h0ABCD);
    stepCycle();
    checkOutput("to_err_single", {31'b0, timeout_err}, 32'd0);
    checkOutput("to_frame_cnt", {24'b0, frame_cnt}, 32'd2);

    $display("[TB] capture on last wait cycle");
    loadFrame(1'b0, 1'b0);
    checkStream(10);
    stepCycle();
    for (int c = 0; c < 14; c++) stepCycle();
    checkOutput("late_res_valid_pre", {31'b0, res_valid}, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 19'sh30F0F, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("late_res_valid", {31'b0, res_valid}, 32'd1);
    checkOutput("late_res_data", {13'b0, res_data}, 32'h30F0F);
    checkOutput("late_no_err", {31'b0, timeout_err}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("late_frame_cnt", {24'b0, frame_cnt}, 32'd3);

    $display("[TB] signed extremes");
    frameSmp[0] = -9'sd256; frameSmp[1] = 9'sd255; frameSmp[2] = -9'sd1;
    frameSmp[3] = 9'sd1;    frameSmp[4] = -9'sd128; frameSmp[5] = 9'sd127;
    frameSmp[6] = 9'sd0;    frameSmp[7] = -9'sd255; frameSmp[8] = 9'sd254;
    frameSmp[9] = -9'sd2;
    loadFrame(1'b0, 1'b0);
    checkStream(10);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1, 19'sh7FFFF, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("ext_res_data", {13'b0, res_data}, 32'h7FFFF);
    checkOutput("ext_res_signed", 32'($signed(res_data)), 32'hFFFFFFFF);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("ext_frame_cnt", {24'b0, frame_cnt}, 32'd4);

    $display("[TB] frame counter wrap");
    for (int f = 0; f < 251; f++) quickFrame();
    checkOutput("wrap_cnt_255", {24'b0, frame_cnt}, 32'd255);
    quickFrame();
    checkOutput("wrap_cnt_0", {24'b0, frame_cnt}, 32'd0);
    checkOutput("wrap_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("wrap_res_valid", {31'b0, res_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_feeder.md
FRAME_FEEDER -- requirements
Module: frame_feeder

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 10, giving the number of samples per frame (legal range 2..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum WAIT cycles allowed for a result.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-006 The block SHALL have port in_data, input, 9 bits signed: upstream sample.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 The block SHALL have port sig, output, 9 bits signed: sample streamed to the downstream filter.
REQ-009 The block SHALL have port run, output, 1 bit: filter enable, high only while streaming; low holds the filter cleared.
REQ-010 The block SHALL have port filter_out, input, 19 bits signed: filter result.
REQ-011 The block SHALL have port out_sig, input, 1 bit: filter result strobe.
REQ-012 The block SHALL have port res_valid, output, 1 bit: captured result available.
REQ-013 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-014 The block SHALL have port res_data, output, 19 bits signed: captured result.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when no result arrives in time.
REQ-016 The block SHALL have port frame_cnt, output, 8 bits: count of delivered results, wrapping.

Function
REQ-017 The FSM SHALL have states LOAD, STREAM, WAIT and HOLD, and SHALL enter LOAD on reset.
REQ-018 In LOAD, in_ready SHALL be 1; each cycle with in_valid&&in_ready SHALL store in_data at buf[wr_cnt] and increment wr_cnt. Idle cycles (in_valid=0) store nothing.
REQ-019 When the FRAME_LEN-th sample is accepted, the FSM SHALL move to STREAM on the next cycle, with wr_cnt=0 and in_ready=0.
REQ-020 In STREAM, run SHALL be 1 for exactly FRAME_LEN consecutive cycles, and sig SHALL equal buf[0]..buf[FRAME_LEN-1] in order, one sample per cycle. There is no gap and no stall.
REQ-021 After the last STREAM cycle, the FSM SHALL enter WAIT. In LOAD, WAIT and HOLD, run SHALL be 0 and sig SHALL be 0.
REQ-022 In WAIT, the first cycle with out_sig=1 SHALL latch filter_out into res_data verbatim, with no shift or saturation. The FSM SHALL enter HOLD and set res_valid=1 on the next cycle.
REQ-023 out_sig SHALL be ignored in LOAD, STREAM and HOLD.
REQ-024 In WAIT, a cycle counter SHALL count from 0. If it reaches TIMEOUT with no out_sig, the block SHALL:
- pulse timeout_err for 1 cycle;
- leave res_valid and res_data unchanged;
- return to LOAD.
REQ-025 If out_sig=1 on the same cycle the counter reaches TIMEOUT, the capture SHALL win and timeout_err SHALL stay 0.
REQ-026 In HOLD, res_valid SHALL stay 1 and res_data SHALL stay stable until res_valid&&res_ready.
REQ-027 On the HOLD handshake cycle, the block SHALL:
- clear res_valid next cycle;
- increment frame_cnt (255 wraps to 0);
- enter LOAD, so in_ready=1 on the following cycle.
REQ-028 The block SHALL NOT accept in_data in any state other than LOAD. The buffer SHALL NOT be overwritten before streaming completes.
REQ-029 res_valid SHALL NOT depend combinationally on res_ready. in_ready SHALL be a function of state only.

Reset
REQ-030 While reset=1, at each clock edge the block SHALL set:
- state=LOAD;
- wr_cnt, rd_cnt and the wait counter = 0;
- run=0, sig=0;
- res_valid=0, res_data=0;
- timeout_err=0, frame_cnt=0;
- in_ready=1 from the first cycle after reset deasserts.
REQ-031 Reset in any state SHALL discard the partial or streamed frame and any uncollected result. Buffer contents need not be cleared.
REQ-032 Reset SHALL take priority over every simultaneous handshake, out_sig or timeout.

Verification
REQ-033 Frame path: load samples 1..10 back-to-back; filter model returns out_sig in the first WAIT cycle with filter_out=19'sh00123. Required: run high for exactly 10 cycles with sig = 1..10; res_valid=1 with res_data=0x00123; after the handshake, frame_cnt=1.
REQ-034 Backpressure: toggle in_valid every other cycle; hold res_ready=0 for 5 cycles in HOLD. Required: all 10 samples are stored in order; res_data is stable through the stall; in_ready=0 throughout HOLD.
REQ-035 Timeout: the model never asserts out_sig. Required: timeout_err pulses exactly once, 15 cycles after WAIT entry; res_valid stays 0; in_ready=1 on the next cycle. A case with out_sig on cycle 15 is captured with no error.
REQ-036 Reset mid-STREAM after 4 samples are streamed. Required: next cycle run=0, sig=0, in_ready=1, frame_cnt unchanged at 0. A new frame then streams only its own samples.
REQ-037 Signed extremes: samples -256 and 255 are streamed verbatim, and filter_out=19'h7FFFF is captured as -1. Run 256 frames: frame_cnt wraps to 0.
